// File: rtl/data_cache_ctrl_if.sv
// CPU load/store port and block-memory port of the data cache, bundled as one interface.
// slave is the cache's view; master is the CPU/memory side that drives it.
interface data_cache_ctrl_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks x 4 bytes,
// one outstanding block transfer toward memory at a time.
module data_cache_ctrl (
  input  logic              CLK,
  input  logic              RESET,
  data_cache_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  valid_q, dirty_q;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic [2:0]  req_tag_q, req_tag_d;
  logic [2:0]  req_idx_q, req_idx_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [5:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]  idx, tg;
  logic [1:0]  off;
  logic        req, hit;
  logic        store_hit, wb_done, fill;

  assign tg  = bus.ADDRESS[7:5];
  assign idx = bus.ADDRESS[4:2];
  assign off = bus.ADDRESS[1:0];
  assign req = bus.READ || bus.WRITE;
  assign hit = valid_q[idx] && (tag_q[idx] == tg);

  assign bus.BUSYWAIT      = !RESET && req && !(state_q == IDLE && hit);
  assign bus.READDATA      = data_q[idx][{off, 3'b000} +: 8];
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = mem_addr_q;
  assign bus.MEM_WRITEDATA = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    store_hit   = 1'b0;
    wb_done     = 1'b0;
    fill        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            store_hit = bus.WRITE;
          end else begin
            req_tag_d = tg;
            req_idx_d = idx;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[idx], idx};
              mem_wdata_d = data_q[idx];
            end else begin
              state_d    = FETCH;
              mem_read_d = 1'b1;
              mem_addr_d = {tg, idx};
            end
          end
        end
      end
      WRITEBACK: begin
        // Hand over straight from write to read on the completing edge so the
        // two requests never overlap and no idle cycle is inserted.
        if (!bus.MEM_BUSYWAIT) begin
          wb_done     = 1'b1;
          state_d     = FETCH;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {req_tag_q, req_idx_q};
        end
      end
      FETCH: begin
        if (!bus.MEM_BUSYWAIT) begin
          fill       = 1'b1;
          state_d    = IDLE;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Fill and writeback use the latched index so CPU address changes mid-miss are harmless.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      if (store_hit) begin
        data_q[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
        dirty_q[idx]                    <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[req_idx_q] <= 1'b0;
      end
      if (fill) begin
        data_q[req_idx_q]  <= bus.MEM_READDATA;
        tag_q[req_idx_q]   <= req_tag_q;
        valid_q[req_idx_q] <= 1'b1;
        dirty_q[req_idx_q] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: behavioural block memory with programmable
// busy time, scoreboards for load data and memory transfers.
module tb_data_cache_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_cache_ctrl_if bus ();

  data_cache_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_xq[$];
  xfer_t       obs_xq[$];
  logic [7:0]  exp_rq[$];
  logic [31:0] mem [64];
  int unsigned lat = 0;
  int unsigned cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cyc = 0;
  bit          both_seen = 1'b0;

  // Memory holds MEM_BUSYWAIT high for 'lat' cycles of each transfer.
  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (cnt < lat);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS];

  always @(posedge CLK) begin
    if ((bus.MEM_READ || bus.MEM_WRITE) && !bus.MEM_BUSYWAIT) begin
      cnt <= 0;
      if (bus.MEM_WRITE) begin
        mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
        obs_xq.push_back({1'b1, bus.MEM_ADDRESS, bus.MEM_WRITEDATA});
      end else begin
        obs_xq.push_back({1'b0, bus.MEM_ADDRESS, bus.MEM_READDATA});
      end
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      cnt <= cnt + 1;
    end else begin
      cnt <= 0;
    end
  end

  always @(negedge CLK) begin
    if (bus.MEM_READ && bus.MEM_WRITE) both_seen <= 1'b1;
    if (bus.MEM_READ) rd_cyc <= rd_cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access: drive, wait (bounded) for BUSYWAIT low, score data, cycles and transfers.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd,
                        input int exp_cyc, input string tag);
    int    cyc;
    xfer_t e, o;
    @(posedge CLK); #1;
    bus.READ      = rd;
    bus.WRITE     = wr;
    bus.ADDRESS   = a;
    bus.WRITEDATA = wd;
    if (rd && !wr) exp_rq.push_back(exp_rd);
    #1;
    cyc = 1;
    while (bus.BUSYWAIT && cyc < 200) begin
      @(posedge CLK); #2;
      cyc++;
    end
    check({tag, "_busy"}, 64'(bus.BUSYWAIT), 64'(0));
    check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    if (rd && !wr) check({tag, "_data"}, 64'(bus.READDATA), 64'(exp_rq.pop_front()));
    @(posedge CLK); #1;
    bus.READ  = 1'b0;
    bus.WRITE = 1'b0;
    check({tag, "_nxfer"}, 64'(obs_xq.size()), 64'(exp_xq.size()));
    while (exp_xq.size() > 0 && obs_xq.size() > 0) begin
      e = exp_xq.pop_front();
      o = obs_xq.pop_front();
      check({tag, "_xfer"}, 64'(o), 64'(e));
    end
    exp_xq.delete();
    obs_xq.delete();
  endtask

  initial begin
    int r0;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[6'h00] = 32'h44332211;
    mem[6'h08] = 32'hCAFEBABE;
    mem[6'h3F] = 32'h11223344;
    mem[6'h07] = 32'h77665544;
    RESET         = 1'b1;
    bus.READ      = 1'b1;
    bus.WRITE     = 1'b0;
    bus.ADDRESS   = 8'h00;
    bus.WRITEDATA = 8'h00;

    repeat (2) @(posedge CLK); #1;
    check("rst_busywait", 64'(bus.BUSYWAIT), 64'(0));
    check("rst_mem_read", 64'(bus.MEM_READ), 64'(0));
    check("rst_mem_write", 64'(bus.MEM_WRITE), 64'(0));
    check("rst_mem_addr", 64'(bus.MEM_ADDRESS), 64'(0));
    check("rst_mem_wdata", 64'(bus.MEM_WRITEDATA), 64'(0));
    check("rst_readdata", 64'(bus.READDATA), 64'(0));
    bus.READ = 1'b0;
    RESET    = 1'b0;

    // Cold clean miss, memory ready at once.
    exp_xq.push_back({1'b0, 6'h00, 32'h44332211});
    r0 = rd_cyc;
    access(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 3, "ld00");
    check("ld00_rdcyc", 64'(rd_cyc - r0), 64'(1));

    access(1'b1, 1'b0, 8'h03, 8'h00, 8'h44, 1, "ld03");
    access(1'b0, 1'b1, 8'h01, 8'hAB, 8'h00, 1, "st01");
    access(1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, 1, "ld01");

    // Dirty miss with slow memory: 5 writeback cycles, 5 fetch cycles.
    lat = 4;
    exp_xq.push_back({1'b1, 6'h00, 32'h4433AB11});
    exp_xq.push_back({1'b0, 6'h08, 32'hCAFEBABE});
    access(1'b1, 1'b0, 8'h20, 8'h00, 8'hBE, 12, "ld20");

    // Store miss at the top address, then evict it to observe the merged byte.
    lat = 0;
    exp_xq.push_back({1'b0, 6'h3F, 32'h11223344});
    access(1'b0, 1'b1, 8'hFF, 8'h5C, 8'h00, 3, "stFF");
    access(1'b1, 1'b0, 8'hFF, 8'h00, 8'h5C, 1, "ldFF");
    exp_xq.push_back({1'b1, 6'h3F, 32'h5C223344});
    exp_xq.push_back({1'b0, 6'h07, 32'h77665544});
    access(1'b1, 1'b0, 8'h1F, 8'h00, 8'h77, 4, "ld1F");

    exp_xq.push_back({1'b0, 6'h00, 32'h4433AB11});
    access(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 3, "ld00b");

    // Reset during the second FETCH cycle of a slow miss.
    lat = 4;
    @(posedge CLK); #1;
    bus.READ    = 1'b1;
    bus.ADDRESS = 8'h04;
    @(posedge CLK);
    @(posedge CLK); #1;
    check("midmiss_mem_read", 64'(bus.MEM_READ), 64'(1));
    RESET = 1'b1;
    #1;
    check("midmiss_rst_busy", 64'(bus.BUSYWAIT), 64'(0));
    @(posedge CLK); #1;
    RESET    = 1'b0;
    bus.READ = 1'b0;
    #1;
    check("post_rst_mem_read", 64'(bus.MEM_READ), 64'(0));
    check("post_rst_mem_write", 64'(bus.MEM_WRITE), 64'(0));
    obs_xq.delete();
    lat = 0;
    exp_xq.push_back({1'b0, 6'h00, 32'h4433AB11});
    access(1'b1, 1'b0, 8'h00, 8'h00, 8'h11, 3, "ld00c");

    check("rw_exclusive", 64'(both_seen), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
